y86_fetch_pipe: RTL and testbench
=================================

Name: y86_fetch_pipe

Overview:
- Registered, pipelined successor of the single-cycle Y86-64 fetch stage.
- Holds the predicted-PC register and selects the fetch PC from three sources: misprediction recovery, ret return address, or the predicted PC.
- Fetches from a byte-addressed instruction memory port, splits the instruction into fields, and computes valP and the next prediction.
- Produces a status code and drives the F->D pipeline register with stall and bubble control.

Parameters:
- ADDR_W, 64, width of PC, valC and valP.
- IMEM_BYTES, 1024, instruction memory size in bytes; any byte at or above it is an address error.
- RESET_PC, 0, value loaded into predPC at reset.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- f_stall  in  1  hold predPC (F stage stall)
- d_stall  in  1  hold D register
- d_bubble  in  1  load NOP bubble into D register
- m_mispredict  in  1  mispredicted jXX in M stage
- m_valA  in  ADDR_W  fall-through PC of the mispredicted jXX
- w_ret  in  1  ret in W stage
- w_valM  in  ADDR_W  return address from W stage
- imem_addr  out  ADDR_W  equals f_pc (combinational)
- imem_data  in  80  10 bytes at imem_addr; byte k at bits [79-8k -: 8]
- imem_error  in  1  memory-side fault
- f_pc  out  ADDR_W  selected fetch PC (combinational)
- f_predPC  out  ADDR_W  predPC register
- f_halted  out  1  fetch frozen after HLT/ADR/INS
- D_stat  out  2  0=AOK, 1=HLT, 2=ADR, 3=INS
- D_icode  out  4  instruction code
- D_ifun  out  4  function code
- D_rA  out  4  register A
- D_rB  out  4  register B
- D_valC  out  ADDR_W  constant word
- D_valP  out  ADDR_W  next sequential PC
- D_valid  out  1  D holds a real instruction, not a bubble

Behaviour:
- Clock is clk. Reset is synchronous and active-high, and overrides every other input on the same edge.
- Reset values:
  - predPC = RESET_PC; f_halted = 0.
  - D register = bubble: stat 0, icode 1 (NOP), ifun 0, rA = rB = 4'hF, valC = 0, valP = 0, valid 0.
- PC select, fixed priority: m_mispredict -> m_valA; else w_ret -> w_valM; else predPC.
- Field split (byte0 = imem_data[79:72]):
  - icode = byte0[7:4]; ifun = byte0[3:0].
  - If need_regids: rA = byte1[7:4], rB = byte1[3:0]; otherwise both = F.
  - valC is little-endian: bytes 2..9 when need_regids, bytes 1..8 otherwise; 0 when not needed.
- Classes:
  - Without regids and valC: 0, 1, 9.
  - regids only: 2, 6, A, B.
  - regids and valC: 3, 4, 5.
  - valC only: 7, 8.
  - Invalid: C-F.
- valP = f_pc + 1 + need_regids + 8*need_valC, in bytes, modulo 2^ADDR_W.
- Next prediction: icode 7 or 8 -> valC; otherwise valP.
- Status, priority ADR > INS > HLT > AOK:
  - ADR when imem_error, or when f_pc + length - 1 >= IMEM_BYTES (computed without wrap), or when f_pc itself is >= IMEM_BYTES.
  - INS for invalid icode.
  - HLT for icode 0.
  - On ADR or INS: icode forced to 1, ifun 0, rA = rB = F, valC = 0.
- predPC update:
  - Loads the next prediction each edge unless f_stall or (f_halted and not m_mispredict).
  - m_mispredict wins over f_stall for the recovery path: predPC loads from the redirected fetch.
- D register:
  - Precedence: reset > d_stall (hold) > d_bubble (load bubble) > load fetched values with valid = 1.
  - d_stall and d_bubble together: stall wins.
- Halt:
  - f_halted sets on the edge a non-AOK instruction loads into D.
  - While set: D is loaded with bubbles (unless d_stall) and predPC holds.
  - m_mispredict clears f_halted on the same edge and fetch resumes at m_valA, because a halt on a wrong path is speculative.
- Latency: one cycle from f_pc to D outputs. The memory read is combinational.

Decomposition:
- Package y86_pkg holds:
  - icode constants IHALT..IPOPQ.
  - A stat_t enum (AOK, HLT, ADR, INS).
  - RNONE = 4'hF.
  - The NOP bubble constant.
- Sub-module y86_instr_class (combinational) maps icode to instr_valid, need_regids, need_valC and a 4-bit length.

Test Plan:
- Reset, then PC 0 holding irmovq (30 F3 + 8-byte valC 0x0102030405060708 LE) -> D_icode 3, rA F, rB 3, valC 0x0102030405060708, valP 10, predPC 10, D_valid 1.
- jXX at PC 0x20 with dest 0x100 -> predPC 0x100. Next cycle m_mispredict with m_valA 0x29 -> f_pc 0x29, with priority over a simultaneous w_ret.
- w_ret with w_valM 0x40 -> f_pc 0x40, valP from 0x40. With f_stall set as well, predPC holds; with d_stall, D holds; with d_stall + d_bubble, D holds.
- icode 0xE byte -> D_stat INS, D_icode 1, f_halted 1. Subsequent cycles give D_valid 0 and predPC held. m_mispredict to 0x50 clears halt and fetches 0x50.
- IMEM_BYTES = 1024, irmovq at PC 1020 (needs 10 bytes) -> D_stat ADR. imem_error at a valid PC also -> ADR.
- Reset asserted mid-stream with stall and mispredict active -> next edge predPC = RESET_PC, D = bubble, f_halted 0.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 fetch definitions: instruction codes, status codes and the
// field values of the NOP bubble loaded into the D register.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic [1:0] {
    AOK = 2'd0,
    HLT = 2'd1,
    ADR = 2'd2,
    INS = 2'd3
  } stat_t;

  typedef struct packed {
    stat_t      stat;
    logic [3:0] icode;
    logic [3:0] ifun;
    logic [3:0] ra;
    logic [3:0] rb;
  } d_fields_t;

  localparam d_fields_t NOP_BUBBLE = '{stat: AOK, icode: INOP, ifun: 4'h0,
                                       ra: RNONE, rb: RNONE};

endpackage

// File: rtl/y86_instr_class.sv
// Decodes an icode into validity, which optional fields follow the opcode
// byte, and the resulting instruction length in bytes.
module y86_instr_class
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  output logic       instr_valid,
  output logic       need_regids,
  output logic       need_valc,
  output logic [3:0] length
);

  always_comb begin
    instr_valid = 1'b1;
    need_regids = 1'b0;
    need_valc   = 1'b0;
    case (icode)
      IHALT, INOP, IRET: ;
      IRRMOVQ, IOPQ, IPUSHQ, IPOPQ: need_regids = 1'b1;
      IIRMOVQ, IRMMOVQ, IMRMOVQ: begin
        need_regids = 1'b1;
        need_valc   = 1'b1;
      end
      IJXX, ICALL: need_valc = 1'b1;
      default: instr_valid = 1'b0;
    endcase
  end

  // Invalid opcodes are treated as one byte long.
  assign length = 4'd1 + {3'b000, need_regids} + {need_valc, 3'b000};

endmodule

// File: rtl/y86_fetch_pipe.sv
// Pipelined Y86-64 fetch stage: PC select, instruction split, status
// generation, predicted-PC register and the F->D pipeline register.
module y86_fetch_pipe
  import y86_pkg::*;
#(
  parameter int                ADDR_W     = 64,
  parameter int                IMEM_BYTES = 1024,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_stall,
  input  logic              d_stall,
  input  logic              d_bubble,
  input  logic              m_mispredict,
  input  logic [ADDR_W-1:0] m_valA,
  input  logic              w_ret,
  input  logic [ADDR_W-1:0] w_valM,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [79:0]       imem_data,
  input  logic              imem_error,
  output logic [ADDR_W-1:0] f_pc,
  output logic [ADDR_W-1:0] f_predPC,
  output logic              f_halted,
  output logic [1:0]        D_stat,
  output logic [3:0]        D_icode,
  output logic [3:0]        D_ifun,
  output logic [3:0]        D_rA,
  output logic [3:0]        D_rB,
  output logic [ADDR_W-1:0] D_valC,
  output logic [ADDR_W-1:0] D_valP,
  output logic              D_valid
);

  logic [ADDR_W-1:0] pred_pc;
  logic              halted;
  d_fields_t         d_q;
  logic [ADDR_W-1:0] d_valc_q;
  logic [ADDR_W-1:0] d_valp_q;
  logic              d_valid_q;

  logic [7:0]        ibyte [10];
  logic [3:0]        raw_icode;
  logic              instr_valid;
  logic              need_regids;
  logic              need_valc;
  logic [3:0]        length;
  logic [63:0]       valc_full;
  logic [ADDR_W-1:0] valc;
  logic [ADDR_W-1:0] valp;
  logic [ADDR_W:0]   last_byte;
  logic              addr_bad;
  d_fields_t         f_fields;
  logic [ADDR_W-1:0] f_valc;
  logic [ADDR_W-1:0] next_pred;
  logic              d_load;

  assign f_pc      = m_mispredict ? m_valA : (w_ret ? w_valM : pred_pc);
  assign imem_addr = f_pc;

  always_comb begin
    for (int k = 0; k < 10; k++) ibyte[k] = imem_data[79-8*k -: 8];
  end

  assign raw_icode = ibyte[0][7:4];

  y86_instr_class u_class (
    .icode       (raw_icode),
    .instr_valid (instr_valid),
    .need_regids (need_regids),
    .need_valc   (need_valc),
    .length      (length)
  );

  // valC is little-endian and starts right after the register byte, if any.
  always_comb begin
    valc_full = '0;
    if (need_valc) begin
      if (need_regids)
        valc_full = {ibyte[9], ibyte[8], ibyte[7], ibyte[6],
                     ibyte[5], ibyte[4], ibyte[3], ibyte[2]};
      else
        valc_full = {ibyte[8], ibyte[7], ibyte[6], ibyte[5],
                     ibyte[4], ibyte[3], ibyte[2], ibyte[1]};
    end
  end

  assign valc = valc_full[ADDR_W-1:0];
  assign valp = f_pc + ADDR_W'(length);

  // One extra bit so an instruction running past the top of the address
  // space is still seen as out of range instead of wrapping to zero.
  assign last_byte = {1'b0, f_pc} + (ADDR_W+1)'(length) - (ADDR_W+1)'(1);
  assign addr_bad  = imem_error
                  || (last_byte >= (ADDR_W+1)'(IMEM_BYTES))
                  || (f_pc >= ADDR_W'(IMEM_BYTES));

  always_comb begin
    f_fields.stat  = AOK;
    f_fields.icode = raw_icode;
    f_fields.ifun  = ibyte[0][3:0];
    f_fields.ra    = need_regids ? ibyte[1][7:4] : RNONE;
    f_fields.rb    = need_regids ? ibyte[1][3:0] : RNONE;
    f_valc         = valc;
    if (addr_bad || !instr_valid) begin
      f_fields      = NOP_BUBBLE;
      f_fields.stat = addr_bad ? ADR : INS;
      f_valc        = '0;
    end else if (raw_icode == IHALT) begin
      f_fields.stat = HLT;
    end
  end

  assign next_pred = (raw_icode == IJXX || raw_icode == ICALL) ? valc : valp;

  // A mispredict overrides a (possibly speculative) halt and refetches.
  assign d_load = !d_stall && !d_bubble && (!halted || m_mispredict);

  always_ff @(posedge clk) begin
    if (reset) begin
      pred_pc   <= RESET_PC;
      halted    <= 1'b0;
      d_q       <= NOP_BUBBLE;
      d_valc_q  <= '0;
      d_valp_q  <= '0;
      d_valid_q <= 1'b0;
    end else begin
      if (m_mispredict || (!f_stall && !halted))
        pred_pc <= next_pred;

      if (m_mispredict)
        halted <= d_load && (f_fields.stat != AOK);
      else if (d_load && (f_fields.stat != AOK))
        halted <= 1'b1;

      if (d_stall) begin
        d_q <= d_q;
      end else if (d_load) begin
        d_q       <= f_fields;
        d_valc_q  <= f_valc;
        d_valp_q  <= valp;
        d_valid_q <= 1'b1;
      end else begin
        d_q       <= NOP_BUBBLE;
        d_valc_q  <= '0;
        d_valp_q  <= '0;
        d_valid_q <= 1'b0;
      end
    end
  end

  assign f_predPC = pred_pc;
  assign f_halted = halted;
  assign D_stat   = d_q.stat;
  assign D_icode  = d_q.icode;
  assign D_ifun   = d_q.ifun;
  assign D_rA     = d_q.ra;
  assign D_rB     = d_q.rb;
  assign D_valC   = d_valc_q;
  assign D_valP   = d_valp_q;
  assign D_valid  = d_valid_q;

endmodule

// File: tb/tb_y86_fetch_pipe.sv
// Directed bench for y86_fetch_pipe with a byte-array instruction memory.
module tb_y86_fetch_pipe;

  logic        clk;
  logic        reset;
  logic        f_stall;
  logic        d_stall;
  logic        d_bubble;
  logic        m_mispredict;
  logic [63:0] m_valA;
  logic        w_ret;
  logic [63:0] w_valM;
  logic [63:0] imem_addr;
  logic [79:0] imem_data;
  logic        imem_error;
  logic [63:0] f_pc;
  logic [63:0] f_predPC;
  logic        f_halted;
  logic [1:0]  D_stat;
  logic [3:0]  D_icode;
  logic [3:0]  D_ifun;
  logic [3:0]  D_rA;
  logic [3:0]  D_rB;
  logic [63:0] D_valC;
  logic [63:0] D_valP;
  logic        D_valid;

  int errors = 0;
  int checks = 0;

  logic [7:0]  mem [0:1023];
  logic [63:0] byte_addr;

  y86_fetch_pipe #(.ADDR_W(64), .IMEM_BYTES(1024), .RESET_PC(64'h0)) dut (
    .clk(clk), .reset(reset), .f_stall(f_stall), .d_stall(d_stall),
    .d_bubble(d_bubble), .m_mispredict(m_mispredict), .m_valA(m_valA),
    .w_ret(w_ret), .w_valM(w_valM), .imem_addr(imem_addr),
    .imem_data(imem_data), .imem_error(imem_error), .f_pc(f_pc),
    .f_predPC(f_predPC), .f_halted(f_halted), .D_stat(D_stat),
    .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
    .D_valC(D_valC), .D_valP(D_valP), .D_valid(D_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ten bytes starting at imem_addr; bytes beyond memory read as zero.
  always_comb begin
    imem_data = '0;
    byte_addr = '0;
    for (int k = 0; k < 10; k++) begin
      byte_addr = imem_addr + 64'(k);
      if (byte_addr < 64'd1024)
        imem_data[79-8*k -: 8] = mem[byte_addr[9:0]];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctrl();
    reset = 0; f_stall = 0; d_stall = 0; d_bubble = 0;
    m_mispredict = 0; m_valA = '0; w_ret = 0; w_valM = '0; imem_error = 0;
  endtask

  task automatic redirect(input logic [63:0] pc);
    clear_ctrl();
    m_mispredict = 1; m_valA = pc;
    step();
    m_mispredict = 0;
    #1;
  endtask

  task automatic test_reset();
    clear_ctrl();
    reset = 1;
    step();
    reset = 0;
    #1;
    checks++; if (f_predPC !== 64'h0) begin errors++; $display("FAIL reset_predpc got=%h exp=%h", f_predPC, 64'h0); end
    checks++; if (f_halted !== 1'b0) begin errors++; $display("FAIL reset_halted got=%b exp=0", f_halted); end
    checks++; if (D_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", D_valid); end
    checks++; if ({D_stat, D_icode, D_ifun, D_rA, D_rB} !== {2'd0, 4'h1, 4'h0, 4'hF, 4'hF}) begin errors++; $display("FAIL reset_bubble got=%h exp=%h", {D_stat, D_icode, D_ifun, D_rA, D_rB}, {2'd0, 4'h1, 4'h0, 4'hF, 4'hF}); end
    checks++; if ({D_valC, D_valP} !== 128'h0) begin errors++; $display("FAIL reset_valc_valp got=%h exp=0", {D_valC, D_valP}); end
    checks++; if (f_pc !== 64'h0) begin errors++; $display("FAIL reset_fpc got=%h exp=0", f_pc); end
  endtask

  task automatic test_irmovq();
    step();
    checks++; if ({D_icode, D_rA, D_rB} !== {4'h3, 4'hF, 4'h3}) begin errors++; $display("FAIL irmovq_fields got=%h exp=%h", {D_icode, D_rA, D_rB}, {4'h3, 4'hF, 4'h3}); end
    checks++; if (D_valC !== 64'h0102030405060708) begin errors++; $display("FAIL irmovq_valc got=%h exp=%h", D_valC, 64'h0102030405060708); end
    checks++; if (D_valP !== 64'd10) begin errors++; $display("FAIL irmovq_valp got=%h exp=%h", D_valP, 64'd10); end
    checks++; if (f_predPC !== 64'd10) begin errors++; $display("FAIL irmovq_predpc got=%h exp=%h", f_predPC, 64'd10); end
    checks++; if ({D_valid, D_stat} !== {1'b1, 2'd0}) begin errors++; $display("FAIL irmovq_valid_stat got=%b exp=100", {D_valid, D_stat}); end
    // back-to-back: nop at 10 follows directly
    step();
    checks++; if ({D_icode, D_valP, D_valid} !== {4'h1, 64'd11, 1'b1}) begin errors++; $display("FAIL b2b_nop got=%h exp=%h", {D_icode, D_valP, D_valid}, {4'h1, 64'd11, 1'b1}); end
  endtask

  task automatic test_jump_mispredict();
    clear_ctrl();
    m_mispredict = 1; m_valA = 64'h20;
    #1;
    checks++; if (f_pc !== 64'h20) begin errors++; $display("FAIL redirect_fpc got=%h exp=%h", f_pc, 64'h20); end
    step();
    checks++; if ({D_icode, D_valC, D_valP} !== {4'h7, 64'h100, 64'h29}) begin errors++; $display("FAIL jxx_fields got=%h exp=%h", {D_icode, D_valC, D_valP}, {4'h7, 64'h100, 64'h29}); end
    checks++; if (f_predPC !== 64'h100) begin errors++; $display("FAIL jxx_predpc got=%h exp=%h", f_predPC, 64'h100); end
    m_valA = 64'h29; w_ret = 1; w_valM = 64'h40;
    #1;
    checks++; if (f_pc !== 64'h29) begin errors++; $display("FAIL mispredict_priority got=%h exp=%h", f_pc, 64'h29); end
    step();
    checks++; if ({D_icode, D_valP, f_predPC} !== {4'h1, 64'h2A, 64'h2A}) begin errors++; $display("FAIL mispredict_fetch got=%h exp=%h", {D_icode, D_valP, f_predPC}, {4'h1, 64'h2A, 64'h2A}); end
  endtask

  task automatic test_ret_stall();
    clear_ctrl();
    w_ret = 1; w_valM = 64'h40;
    #1;
    checks++; if (f_pc !== 64'h40) begin errors++; $display("FAIL ret_fpc got=%h exp=%h", f_pc, 64'h40); end
    step();
    checks++; if ({D_icode, D_rA, D_rB, D_valP} !== {4'h6, 4'h0, 4'h1, 64'h42}) begin errors++; $display("FAIL ret_fetch got=%h exp=%h", {D_icode, D_rA, D_rB, D_valP}, {4'h6, 4'h0, 4'h1, 64'h42}); end
    checks++; if (f_predPC !== 64'h42) begin errors++; $display("FAIL ret_predpc got=%h exp=%h", f_predPC, 64'h42); end
    f_stall = 1;
    step();
    checks++; if (f_predPC !== 64'h42) begin errors++; $display("FAIL fstall_hold got=%h exp=%h", f_predPC, 64'h42); end
    w_ret = 0; d_stall = 1;
    step();
    checks++; if ({D_icode, D_valid, f_predPC} !== {4'h6, 1'b1, 64'h42}) begin errors++; $display("FAIL dstall_hold got=%h exp=%h", {D_icode, D_valid, f_predPC}, {4'h6, 1'b1, 64'h42}); end
    d_bubble = 1;
    step();
    checks++; if ({D_icode, D_valid} !== {4'h6, 1'b1}) begin errors++; $display("FAIL stall_over_bubble got=%h exp=%h", {D_icode, D_valid}, {4'h6, 1'b1}); end
    d_stall = 0;
    step();
    checks++; if ({D_icode, D_rA, D_valid} !== {4'h1, 4'hF, 1'b0}) begin errors++; $display("FAIL bubble_load got=%h exp=%h", {D_icode, D_rA, D_valid}, {4'h1, 4'hF, 1'b0}); end
  endtask

  task automatic test_invalid();
    redirect(64'h60);
    checks++; if ({D_stat, D_icode, D_ifun, D_rA, D_rB, D_valid} !== {2'd3, 4'h1, 4'h0, 4'hF, 4'hF, 1'b1}) begin errors++; $display("FAIL ins_fields got=%h exp=%h", {D_stat, D_icode, D_ifun, D_rA, D_rB, D_valid}, {2'd3, 4'h1, 4'h0, 4'hF, 4'hF, 1'b1}); end
    checks++; if ({D_valC, f_halted} !== {64'h0, 1'b1}) begin errors++; $display("FAIL ins_halted got=%h exp=%h", {D_valC, f_halted}, {64'h0, 1'b1}); end
    step();
    checks++; if ({D_valid, f_predPC, f_halted} !== {1'b0, 64'h61, 1'b1}) begin errors++; $display("FAIL halted_bubble1 got=%h exp=%h", {D_valid, f_predPC, f_halted}, {1'b0, 64'h61, 1'b1}); end
    step();
    checks++; if ({D_valid, f_predPC} !== {1'b0, 64'h61}) begin errors++; $display("FAIL halted_bubble2 got=%h exp=%h", {D_valid, f_predPC}, {1'b0, 64'h61}); end
    redirect(64'h50);
    checks++; if ({f_halted, D_valid, D_icode, D_rA, D_rB} !== {1'b0, 1'b1, 4'h2, 4'h2, 4'h3}) begin errors++; $display("FAIL resume_fields got=%h exp=%h", {f_halted, D_valid, D_icode, D_rA, D_rB}, {1'b0, 1'b1, 4'h2, 4'h2, 4'h3}); end
    checks++; if ({D_valP, f_predPC} !== {64'h52, 64'h52}) begin errors++; $display("FAIL resume_pc got=%h exp=%h", {D_valP, f_predPC}, {64'h52, 64'h52}); end
  endtask

  task automatic test_halt();
    redirect(64'h70);
    checks++; if ({D_stat, D_icode, D_valid, f_halted} !== {2'd1, 4'h0, 1'b1, 1'b1}) begin errors++; $display("FAIL hlt_fields got=%h exp=%h", {D_stat, D_icode, D_valid, f_halted}, {2'd1, 4'h0, 1'b1, 1'b1}); end
    step();
    checks++; if ({D_valid, f_predPC} !== {1'b0, 64'h71}) begin errors++; $display("FAIL hlt_frozen got=%h exp=%h", {D_valid, f_predPC}, {1'b0, 64'h71}); end
  endtask

  task automatic test_adr();
    redirect(64'd1020);
    checks++; if ({D_stat, D_icode, D_rA, D_rB, f_halted} !== {2'd2, 4'h1, 4'hF, 4'hF, 1'b1}) begin errors++; $display("FAIL adr_range got=%h exp=%h", {D_stat, D_icode, D_rA, D_rB, f_halted}, {2'd2, 4'h1, 4'hF, 4'hF, 1'b1}); end
    checks++; if (D_valC !== 64'h0) begin errors++; $display("FAIL adr_valc got=%h exp=0", D_valC); end
    clear_ctrl();
    m_mispredict = 1; m_valA = 64'h40; imem_error = 1;
    step();
    clear_ctrl();
    checks++; if ({D_stat, D_icode} !== {2'd2, 4'h1}) begin errors++; $display("FAIL adr_imem_error got=%h exp=%h", {D_stat, D_icode}, {2'd2, 4'h1}); end
    redirect(64'h0);
    checks++; if ({D_stat, D_icode, f_halted} !== {2'd0, 4'h3, 1'b0}) begin errors++; $display("FAIL adr_recover got=%h exp=%h", {D_stat, D_icode, f_halted}, {2'd0, 4'h3, 1'b0}); end
  endtask

  task automatic test_reset_midstream();
    redirect(64'h60);
    checks++; if (f_halted !== 1'b1) begin errors++; $display("FAIL pre_reset_halted got=%b exp=1", f_halted); end
    reset = 1; f_stall = 1; m_mispredict = 1; m_valA = 64'h20;
    step();
    clear_ctrl();
    #1;
    checks++; if ({f_predPC, f_halted, D_valid, D_icode, D_stat} !== {64'h0, 1'b0, 1'b0, 4'h1, 2'd0}) begin errors++; $display("FAIL midstream_reset got=%h exp=%h", {f_predPC, f_halted, D_valid, D_icode, D_stat}, {64'h0, 1'b0, 1'b0, 4'h1, 2'd0}); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[0] = 8'h30; mem[1] = 8'hF3;
    mem[2] = 8'h08; mem[3] = 8'h07; mem[4] = 8'h06; mem[5] = 8'h05;
    mem[6] = 8'h04; mem[7] = 8'h03; mem[8] = 8'h02; mem[9] = 8'h01;
    mem[10] = 8'h10;
    mem[32] = 8'h70; mem[33] = 8'h00; mem[34] = 8'h01;
    mem[41] = 8'h10;
    mem[64] = 8'h60; mem[65] = 8'h01; mem[66] = 8'h10;
    mem[80] = 8'h20; mem[81] = 8'h23;
    mem[96] = 8'hE0;
    mem[112] = 8'h00;
    mem[1020] = 8'h30; mem[1021] = 8'hF0;
    clear_ctrl();
    test_reset();
    test_irmovq();
    test_jump_mispredict();
    test_ret_stall();
    test_invalid();
    test_halt();
    test_adr();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
